// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT channel scheduler: FSM state, tag width
// and the round-robin next-grant search.
package fft_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_t;

    // Channel-index width; a 2-channel build still needs one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // First requesting channel at or after ptr, wrapping modulo num_ch (<= 16).
    function automatic logic [3:0] rr_next(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          num_ch);
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_ch)
                idx = idx - num_ch;
            if (i < num_ch && !found && req[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Show-ahead tag FIFO holding the source channel of each frame inside the FFT.
module fft_tag_fifo
    import fft_sched_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer MSB separates a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fft_chan_sched.sv
// Frame scheduler sharing one streaming FFT between NUM_CH channels, N samples
// per grant, round-robin among pending channels, with output-frame channel tags.
//   state  | meaning
//   IDLE   | no frame granted; arbitrate when enabled, requested and tag room
//   STREAM | granted channel feeds the FFT until its N-th sample transfers
module fft_chan_sched
    import fft_sched_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int N         = 1024,
    parameter  int DATA_W    = 16,
    parameter  int TAG_DEPTH = 4,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_real,
    input  logic [NUM_CH*DATA_W-1:0] ch_imag,
    output logic                     f_valid,
    input  logic                     f_ready,
    output logic [DATA_W-1:0]        f_real,
    output logic [DATA_W-1:0]        f_imag,
    output logic                     f_last,
    input  logic                     fo_valid,
    input  logic                     fo_ready,
    input  logic                     fo_last,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_ch_valid,
    output logic                     busy,
    output logic                     tag_err
);
    localparam int               CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    sched_state_t    state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [15:0]     req_ext;
    logic [CH_W-1:0] nxt_grant;
    logic            start;
    logic            tag_pop;
    logic            tag_full;
    logic            tag_empty;
    logic            xfer;

    always_comb begin
        req_ext               = '0;
        req_ext[NUM_CH-1:0]   = ch_valid;
    end

    assign nxt_grant = CH_W'(rr_next(req_ext, 4'(rr_ptr), NUM_CH));
    assign start     = (state == IDLE) && en && (|ch_valid) && !tag_full;
    assign tag_pop   = fo_valid && fo_ready && fo_last;
    assign xfer      = f_valid && f_ready;
    assign busy      = (state == STREAM);

    always_comb begin
        f_valid         = busy && ch_valid[grant];
        f_real          = ch_real[int'(grant)*DATA_W +: DATA_W];
        f_imag          = ch_imag[int'(grant)*DATA_W +: DATA_W];
        f_last          = f_valid && (cnt == LAST);
        ch_ready        = '0;
        ch_ready[grant] = busy && f_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            tag_err <= 1'b0;
        end else begin
            if (tag_pop && tag_empty)
                tag_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant <= nxt_grant;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (cnt == LAST) begin
                            cnt    <= '0;
                            rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft_tag_fifo #(
        .W     (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (start),
        .din   (nxt_grant),
        .pop   (tag_pop),
        .dout  (out_ch),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign out_ch_valid = !tag_empty;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ch_ready));
    a_last_valid:    assert property (@(posedge clk) disable iff (!rst_n) f_last |-> f_valid);
    a_valid_hold:    assert property (@(posedge clk) disable iff (!rst_n)
                                      (busy && f_valid && !f_ready) |=> f_valid);

endmodule

// File: tb/tb_fft_chan_sched.sv
// Directed bench for fft_chan_sched with N=8, four channels, four-deep tag FIFO.
module tb_fft_chan_sched;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [63:0] ch_real;
    logic [63:0] ch_imag;
    logic        f_valid;
    logic        f_ready;
    logic [15:0] f_real;
    logic [15:0] f_imag;
    logic        f_last;
    logic        fo_valid;
    logic        fo_ready;
    logic        fo_last;
    logic [1:0]  out_ch;
    logic        out_ch_valid;
    logic        busy;
    logic        tag_err;

    int checks = 0;
    int errors = 0;

    fft_chan_sched #(
        .NUM_CH    (4),
        .N         (8),
        .DATA_W    (16),
        .TAG_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_real      (ch_real),
        .ch_imag      (ch_imag),
        .f_valid      (f_valid),
        .f_ready      (f_ready),
        .f_real       (f_real),
        .f_imag       (f_imag),
        .f_last       (f_last),
        .fo_valid     (fo_valid),
        .fo_ready     (fo_ready),
        .fo_last      (fo_last),
        .out_ch       (out_ch),
        .out_ch_valid (out_ch_valid),
        .busy         (busy),
        .tag_err      (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the first STREAM cycle; walks the frame to its N-th transfer.
    task automatic frame(input int ch, input bit toggle);
        int   acc;
        int   cyc;
        logic r;
        acc = 0;
        cyc = 0;
        chk("busy_start", busy, 1);
        chk("tag_present", out_ch_valid, 1);
        while (acc < 8) begin
            r = toggle ? ((cyc % 2) == 0) : 1'b1;
            f_ready = r;
            #1;
            chk("ch_ready", ch_ready, r ? (32'd1 << ch) : 32'd0);
            chk("f_valid", f_valid, 1);
            chk("f_last", f_last, acc == 7);
            chk("f_real", f_real, 32'h1000 + ch);
            chk("f_imag", f_imag, 32'h2000 + ch);
            if (r) acc++;
            tick();
            cyc++;
        end
        f_ready = 1'b1;
        #1;
        chk("busy_end", busy, 0);
    endtask

    task automatic next_frame(input int ch, input bit toggle);
        chk("idle_gap", busy, 0);
        tick();
        frame(ch, toggle);
    endtask

    task automatic pop_tag(input int ch);
        chk("pop_valid", out_ch_valid, 1);
        chk("pop_ch", out_ch, ch);
        fo_valid = 1'b1;
        fo_ready = 1'b1;
        fo_last  = 1'b1;
        tick();
        fo_valid = 1'b0;
        fo_ready = 1'b0;
        fo_last  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        ch_valid = '0;
        f_ready  = 1'b0;
        fo_valid = 1'b0;
        fo_ready = 1'b0;
        fo_last  = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            ch_real[c*16 +: 16] = 16'h1000 + 16'(c);
            ch_imag[c*16 +: 16] = 16'h2000 + 16'(c);
        end

        // reset values
        do_reset();
        chk("rst_ch_ready", ch_ready, 0);
        chk("rst_f_valid", f_valid, 0);
        chk("rst_f_last", f_last, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_ch_valid", out_ch_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag_err", tag_err, 0);

        // single channel 2, back-to-back frames
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b0100;
        #1;
        next_frame(2, 1'b0);
        next_frame(2, 1'b0);
        ch_valid = 4'b0000;
        #1;
        pop_tag(2);
        pop_tag(2);
        chk("drained", out_ch_valid, 0);

        // round-robin over channels 0,1,3
        do_reset();
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b1011;
        #1;
        next_frame(0, 1'b0);
        next_frame(1, 1'b0);
        next_frame(3, 1'b0);
        ch_valid = 4'b0000;
        #1;
        pop_tag(0); pop_tag(1); pop_tag(3);
        ch_valid = 4'b1011;
        #1;
        next_frame(0, 1'b0);
        next_frame(1, 1'b0);
        next_frame(3, 1'b0);
        ch_valid = 4'b0000;
        #1;
        pop_tag(0); pop_tag(1); pop_tag(3);

        // backpressure with f_ready toggling
        do_reset();
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b0001;
        #1;
        next_frame(0, 1'b1);
        ch_valid = 4'b0000;
        #1;
        pop_tag(0);

        // tag FIFO full holds the scheduler in IDLE
        do_reset();
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b0110;
        #1;
        next_frame(1, 1'b0);
        next_frame(2, 1'b0);
        next_frame(1, 1'b0);
        next_frame(2, 1'b0);
        tick();
        chk("full_hold", busy, 0);
        tick();
        chk("full_hold2", busy, 0);
        pop_tag(1);
        chk("pop_edge_idle", busy, 0);
        next_frame(1, 1'b0);
        ch_valid = 4'b0000;
        #1;
        pop_tag(2); pop_tag(1); pop_tag(2); pop_tag(1);
        chk("full_drained", out_ch_valid, 0);

        // en dropped at cnt=3: frame completes, no new grant
        do_reset();
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b0001;
        #1;
        chk("en_idle", busy, 0);
        tick();
        chk("en_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            chk("en_f_last_early", f_last, 0);
            tick();
        end
        en = 1'b0;
        for (int i = 3; i < 8; i++) begin
            #1;
            chk("en_busy_hold", busy, 1);
            chk("en_f_last", f_last, i == 7);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("en_no_grant", busy, 0);
            tick();
        end
        ch_valid = 4'b0000; en = 1'b1;
        #1;
        pop_tag(0);

        // output frame end with empty FIFO sets sticky tag_err
        chk("tag_err_clear", tag_err, 0);
        fo_valid = 1'b1; fo_ready = 1'b1; fo_last = 1'b1;
        tick();
        fo_valid = 1'b0; fo_ready = 1'b0; fo_last = 1'b0;
        #1;
        chk("tag_err_set", tag_err, 1);
        chk("tag_err_empty", out_ch_valid, 0);
        tick(); tick(); tick();
        chk("tag_err_sticky", tag_err, 1);

        // reset mid-frame at cnt=5
        do_reset();
        chk("tag_err_rst", tag_err, 0);
        en = 1'b1; f_ready = 1'b1; ch_valid = 4'b0100;
        #1;
        tick();
        chk("mid_grant", ch_ready, 32'h4);
        for (int i = 0; i < 5; i++) tick();
        ch_valid = 4'b0101;
        rst_n = 1'b0;
        #1;
        chk("mid_f_valid", f_valid, 0);
        chk("mid_ch_ready", ch_ready, 0);
        chk("mid_out_ch_valid", out_ch_valid, 0);
        chk("mid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_idle", busy, 0);
        tick();
        chk("post_grant", ch_ready, 32'h1);
        chk("post_out_ch", out_ch, 0);
        chk("post_tag", out_ch_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
